// File: rtl/grid_navigator_pkg.sv
// Shared definitions for the grid navigator and its cell checker.
//   - direction codes carried on req_dir
//   - FSM state encoding
//   - default level geometry and wall bitmap
package grid_navigator_pkg;

  localparam int unsigned DIR_W = 3;

  localparam logic [DIR_W-1:0] DIR_UP    = 3'd0;
  localparam logic [DIR_W-1:0] DIR_DOWN  = 3'd1;
  localparam logic [DIR_W-1:0] DIR_RIGHT = 3'd2;
  localparam logic [DIR_W-1:0] DIR_LEFT  = 3'd3;
  localparam logic [DIR_W-1:0] DIR_NONE  = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int unsigned DEF_GRID_W = 8;
  localparam int unsigned DEF_GRID_H = 4;

  // Walls at (3,0) (6,0) (4,1) (0,2) (2,2) (6,2) (2,3) (6,3); bit y*GRID_W+x.
  localparam logic [31:0] DEF_WALL_MAP = 32'h44451048;

endpackage

// File: rtl/grid_navigator_if.sv
// Request/response bundle between the command decoder and the navigator.
//   master : requester (drives req_*, load_*; observes position and results)
//   slave  : navigator
interface grid_navigator_if #(
  parameter int unsigned X_W   = 3,
  parameter int unsigned Y_W   = 2,
  parameter int unsigned CNT_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_dir;
  logic             req_load;
  logic [X_W-1:0]   load_x;
  logic [Y_W-1:0]   load_y;
  logic [X_W-1:0]   pos_x;
  logic [Y_W-1:0]   pos_y;
  logic             done;
  logic             blocked;
  logic [CNT_W-1:0] step_count;

  modport master (
    output req_valid, req_dir, req_load, load_x, load_y,
    input  req_ready, pos_x, pos_y, done, blocked, step_count
  );

  modport slave (
    input  req_valid, req_dir, req_load, load_x, load_y,
    output req_ready, pos_x, pos_y, done, blocked, step_count
  );
endinterface

// File: rtl/grid_navigator_cell_check.sv
// grid_cell_check: combinational bounds and wall lookup for one target cell.
// Optional feature macro: GRID_NAVIGATOR_WRAP_EN (adds toroidal wrapped coords).
// Ports:
//   i_x, i_y       signed target coordinates (one bit wider than the grid coords)
//   o_in_range     target lies inside the grid
//   o_is_wall      wall bit of the checked cell (wrapped cell when wrapping)
//   o_wrap_x/y     wrapped coordinates (macro only)
module grid_cell_check
  import grid_navigator_pkg::*;
#(
  parameter int unsigned GRID_W = DEF_GRID_W,
  parameter int unsigned GRID_H = DEF_GRID_H,
  parameter int unsigned X_W    = 3,
  parameter int unsigned Y_W    = 2,
  parameter logic [GRID_W*GRID_H-1:0] WALL_MAP = (GRID_W*GRID_H)'(DEF_WALL_MAP)
) (
  input  logic signed [X_W:0] i_x,
  input  logic signed [Y_W:0] i_y,
  output logic                o_in_range,
`ifdef GRID_NAVIGATOR_WRAP_EN
  output logic [X_W-1:0]      o_wrap_x,
  output logic [Y_W-1:0]      o_wrap_y,
`endif
  output logic                o_is_wall
);

  localparam int unsigned N_CELLS = GRID_W * GRID_H;
  localparam int unsigned IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;

  logic [X_W:0]     w_xu;
  logic [Y_W:0]     w_yu;
  logic             w_x_neg, w_y_neg, w_x_hi, w_y_hi;
  logic [X_W-1:0]   w_cx;
  logic [Y_W-1:0]   w_cy;
  logic [IDX_W-1:0] w_idx;

  assign w_xu = $unsigned(i_x);
  assign w_yu = $unsigned(i_y);

  // pos+1 from the top cell of a full-width axis lands on 100..0; read it as
  // an overflow past the far edge, not as a negative coordinate.
  assign w_x_neg = w_xu[X_W] && (w_xu[X_W-1:0] != '0);
  assign w_y_neg = w_yu[Y_W] && (w_yu[Y_W-1:0] != '0);
  assign w_x_hi  = !w_x_neg && (w_xu >= (X_W+1)'(GRID_W));
  assign w_y_hi  = !w_y_neg && (w_yu >= (Y_W+1)'(GRID_H));

  assign o_in_range = !(w_x_neg || w_x_hi || w_y_neg || w_y_hi);

`ifdef GRID_NAVIGATOR_WRAP_EN
  // Single-step wrap: one cell off either edge maps to the opposite edge.
  assign w_cx = w_x_neg ? X_W'(GRID_W - 1) : (w_x_hi ? '0 : w_xu[X_W-1:0]);
  assign w_cy = w_y_neg ? Y_W'(GRID_H - 1) : (w_y_hi ? '0 : w_yu[Y_W-1:0]);
  assign o_wrap_x = w_cx;
  assign o_wrap_y = w_cy;
  assign w_idx = IDX_W'(int'(w_cy) * int'(GRID_W) + int'(w_cx));
  assign o_is_wall = WALL_MAP[w_idx];
`else
  // Clamp to cell 0 when out of range so the bitmap index stays legal.
  assign w_cx = o_in_range ? w_xu[X_W-1:0] : '0;
  assign w_cy = o_in_range ? w_yu[Y_W-1:0] : '0;
  assign w_idx = IDX_W'(int'(w_cy) * int'(GRID_W) + int'(w_cx));
  assign o_is_wall = o_in_range && WALL_MAP[w_idx];
`endif

endmodule

// File: rtl/grid_navigator.sv
// grid_navigator: registered player position with move/teleport requests.
// Optional feature macro: GRID_NAVIGATOR_WRAP_EN (edge moves wrap toroidally).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         grid_navigator_if.slave: req_valid/req_ready handshake,
//               req_dir, req_load, load_x/y in; pos_x/y, done, blocked,
//               step_count out (all registered)
module grid_navigator
  import grid_navigator_pkg::*;
#(
  parameter int unsigned GRID_W  = DEF_GRID_W,
  parameter int unsigned GRID_H  = DEF_GRID_H,
  parameter int unsigned X_W     = 3,
  parameter int unsigned Y_W     = 2,
  parameter int unsigned START_X = 0,
  parameter int unsigned START_Y = 0,
  parameter logic [GRID_W*GRID_H-1:0] WALL_MAP = (GRID_W*GRID_H)'(DEF_WALL_MAP),
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  grid_navigator_if.slave   bus
);

  localparam logic signed [X_W:0] ONE_X = (X_W+1)'(1);
  localparam logic signed [Y_W:0] ONE_Y = (Y_W+1)'(1);

  state_t              r_state, w_state_nxt;
  logic signed [X_W:0] r_tgt_x, w_tgt_x_nxt;
  logic signed [Y_W:0] r_tgt_y, w_tgt_y_nxt;
  logic                r_is_load, w_is_load_nxt;
  logic [X_W-1:0]      r_pos_x, w_pos_x_nxt;
  logic [Y_W-1:0]      r_pos_y, w_pos_y_nxt;
  logic                r_done, w_done_nxt;
  logic                r_blocked, w_blocked_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_ready, w_ready_nxt;

  logic                w_in_range, w_is_wall, w_reject;
  logic [X_W-1:0]      w_cand_x;
  logic [Y_W-1:0]      w_cand_y;
  logic signed [X_W:0] w_px_s;
  logic signed [Y_W:0] w_py_s;

  assign w_px_s = $signed({1'b0, r_pos_x});
  assign w_py_s = $signed({1'b0, r_pos_y});

  // Bounds/wall check of the latched target.
`ifdef GRID_NAVIGATOR_WRAP_EN
  logic [X_W-1:0] w_wrap_x;
  logic [Y_W-1:0] w_wrap_y;

  grid_cell_check #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W), .WALL_MAP(WALL_MAP)
  ) u_cell_check (
    .i_x        (r_tgt_x),
    .i_y        (r_tgt_y),
    .o_in_range (w_in_range),
    .o_wrap_x   (w_wrap_x),
    .o_wrap_y   (w_wrap_y),
    .o_is_wall  (w_is_wall)
  );

  // Moves can only step one cell off an edge and always wrap; teleports
  // still have to name a real cell.
  assign w_cand_x = w_wrap_x;
  assign w_cand_y = w_wrap_y;
  assign w_reject = r_is_load ? (!w_in_range || w_is_wall) : w_is_wall;
`else
  grid_cell_check #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W), .WALL_MAP(WALL_MAP)
  ) u_cell_check (
    .i_x        (r_tgt_x),
    .i_y        (r_tgt_y),
    .o_in_range (w_in_range),
    .o_is_wall  (w_is_wall)
  );

  assign w_cand_x = r_tgt_x[X_W-1:0];
  assign w_cand_y = r_tgt_y[Y_W-1:0];
  assign w_reject = !w_in_range || w_is_wall;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_tgt_x_nxt   = r_tgt_x;
    w_tgt_y_nxt   = r_tgt_y;
    w_is_load_nxt = r_is_load;
    w_pos_x_nxt   = r_pos_x;
    w_pos_y_nxt   = r_pos_y;
    w_done_nxt    = 1'b0;
    w_blocked_nxt = r_blocked;
    w_cnt_nxt     = r_cnt;

    case (r_state)
      IDLE: begin
        if (bus.req_valid && r_ready) begin
          w_is_load_nxt = bus.req_load;
          if (bus.req_load) begin
            w_tgt_x_nxt = $signed({1'b0, bus.load_x});
            w_tgt_y_nxt = $signed({1'b0, bus.load_y});
          end else begin
            w_tgt_x_nxt = w_px_s;
            w_tgt_y_nxt = w_py_s;
            case (bus.req_dir)
              DIR_UP:    w_tgt_y_nxt = w_py_s - ONE_Y;
              DIR_DOWN:  w_tgt_y_nxt = w_py_s + ONE_Y;
              DIR_RIGHT: w_tgt_x_nxt = w_px_s + ONE_X;
              DIR_LEFT:  w_tgt_x_nxt = w_px_s - ONE_X;
              default: ;
            endcase
          end
          w_state_nxt = CHECK;
        end
      end

      // Result is registered on leaving CHECK so it is visible during COMMIT.
      CHECK: begin
        w_done_nxt    = 1'b1;
        w_blocked_nxt = w_reject;
        if (!w_reject) begin
          w_pos_x_nxt = w_cand_x;
          w_pos_y_nxt = w_cand_y;
          if (((w_cand_x != r_pos_x) || (w_cand_y != r_pos_y)) && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        w_state_nxt = COMMIT;
      end

      COMMIT: w_state_nxt = IDLE;

      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_ready_nxt = (w_state_nxt == IDLE);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_tgt_x   <= '0;
      r_tgt_y   <= '0;
      r_is_load <= 1'b0;
      r_pos_x   <= X_W'(START_X);
      r_pos_y   <= Y_W'(START_Y);
      r_done    <= 1'b0;
      r_blocked <= 1'b0;
      r_cnt     <= '0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_tgt_x   <= w_tgt_x_nxt;
      r_tgt_y   <= w_tgt_y_nxt;
      r_is_load <= w_is_load_nxt;
      r_pos_x   <= w_pos_x_nxt;
      r_pos_y   <= w_pos_y_nxt;
      r_done    <= w_done_nxt;
      r_blocked <= w_blocked_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.pos_x      = r_pos_x;
  assign bus.pos_y      = r_pos_y;
  assign bus.done       = r_done;
  assign bus.blocked    = r_blocked;
  assign bus.step_count = r_cnt;

endmodule

// File: tb/tb_grid_navigator.sv
// Randomized self-checking bench for grid_navigator against a cell-level
// reference model of the level (wall list, bounds, optional wrap).
module tb_grid_navigator;

  localparam int unsigned GW = 8;
  localparam int unsigned GH = 4;
  localparam int unsigned XW = 3;
  localparam int unsigned YW = 2;
  localparam int unsigned CW = 8;
  localparam int          CNT_MAX = 255;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  // Reference model state.
  int m_x, m_y, m_cnt;
  bit m_blk;

  int wall_xs[8] = '{3, 6, 4, 0, 2, 6, 2, 6};
  int wall_ys[8] = '{0, 0, 1, 2, 2, 2, 3, 3};

  grid_navigator_if #(.X_W(XW), .Y_W(YW), .CNT_W(CW)) bus ();

  grid_navigator #(
    .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW),
    .START_X(0), .START_Y(0), .CNT_W(CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_wall(input int x, input int y);
    for (int i = 0; i < 8; i++)
      if (wall_xs[i] == x && wall_ys[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_cnt = 0; m_blk = 1'b0;
  endtask

  // Apply one request to the reference model.
  task automatic model_step(input bit ld, input int dir, input int lx, input int ly);
    int tx, ty;
    bit out;
    tx = m_x; ty = m_y; out = 1'b0;
    if (ld) begin
      tx = lx; ty = ly;
      out = (tx >= GW) || (ty >= GH);
    end else begin
      case (dir)
        0: ty = m_y - 1;
        1: ty = m_y + 1;
        2: tx = m_x + 1;
        3: tx = m_x - 1;
        default: ;
      endcase
`ifdef GRID_NAVIGATOR_WRAP_EN
      tx = (tx + GW) % GW;
      ty = (ty + GH) % GH;
`else
      out = (tx < 0) || (tx >= GW) || (ty < 0) || (ty >= GH);
`endif
    end
    m_blk = out || is_wall(tx, ty);
    if (!m_blk) begin
      if ((tx != m_x || ty != m_y) && m_cnt < CNT_MAX) m_cnt++;
      m_x = tx; m_y = ty;
    end
  endtask

  task automatic check_idle_state(input string tag);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_x"}, int'(bus.pos_x), m_x);
    chk({tag, "_y"}, int'(bus.pos_y), m_y);
    chk({tag, "_cnt"}, int'(bus.step_count), m_cnt);
  endtask

  // One request; returns at the negedge of the COMMIT cycle (T+2).
  // hold_busy keeps a teleport asserted while the FSM is busy.
  task automatic do_req(input bit ld, input int dir, input int lx, input int ly,
                        input bit hold_busy);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus.req_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_idle", int'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_load  = ld;
    bus.req_dir   = 3'(dir);
    bus.load_x    = XW'(lx);
    bus.load_y    = YW'(ly);
    @(posedge clk);
    #1;
    model_step(ld, dir, lx, ly);
    if (hold_busy) begin
      bus.req_load = 1'b1;
      bus.load_x   = XW'(1);
      bus.load_y   = YW'(1);
    end else begin
      bus.req_valid = 1'b0;
      bus.req_load  = 1'($urandom);
      bus.req_dir   = 3'($urandom);
      bus.load_x    = XW'($urandom);
      bus.load_y    = YW'($urandom);
    end
    @(negedge clk);
    chk("done_t1", int'(bus.done), 0);
    chk("ready_t1", int'(bus.req_ready), 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("done_t2", int'(bus.done), 1);
    chk("ready_t2", int'(bus.req_ready), 0);
    chk("blocked", int'(bus.blocked), int'(m_blk));
    chk("pos_x", int'(bus.pos_x), m_x);
    chk("pos_y", int'(bus.pos_y), m_y);
    chk("step_count", int'(bus.step_count), m_cnt);
  endtask

  initial begin
    int dir;
    bit ld;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_load  = 1'b0;
    bus.req_dir   = 3'd4;
    bus.load_x    = '0;
    bus.load_y    = '0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(bus.req_ready), 1);
    check_idle_state("rst");
    rst_n = 1'b1;

    // Directed walk through the level.
    do_req(1'b0, 2, 0, 0, 1'b0);
    chk("first_right_x", int'(bus.pos_x), 1);
    chk("first_right_cnt", int'(bus.step_count), 1);
    do_req(1'b0, 2, 0, 0, 1'b0);
    do_req(1'b0, 2, 0, 0, 1'b0);
    chk("wall_right_blk", int'(bus.blocked), 1);
    chk("wall_right_x", int'(bus.pos_x), 2);
    do_req(1'b1, 0, 0, 0, 1'b0);
    do_req(1'b0, 0, 0, 0, 1'b0);
`ifdef GRID_NAVIGATOR_WRAP_EN
    chk("edge_up_y", int'(bus.pos_y), 3);
`else
    chk("edge_up_blk", int'(bus.blocked), 1);
`endif
    do_req(1'b1, 0, 5, 3, 1'b0);
    chk("tele_x", int'(bus.pos_x), 5);
    do_req(1'b1, 0, 6, 3, 1'b0);
    chk("tele_wall_blk", int'(bus.blocked), 1);
    do_req(1'b1, 0, 5, 3, 1'b0);
    do_req(1'b0, 4, 0, 0, 1'b0);
    do_req(1'b0, 7, 0, 0, 1'b0);

    // Teleport held while busy must not be taken.
    do_req(1'b0, 3, 0, 0, 1'b1);
    @(negedge clk);
    check_idle_state("busy_t3");
    @(negedge clk);
    check_idle_state("busy_t4");

    // Reset while in CHECK discards the request.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_load  = 1'b1;
    bus.load_x    = XW'(1);
    bus.load_y    = YW'(0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_ready", int'(bus.req_ready), 1);
    check_idle_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_state("midrst_t1");
    @(negedge clk);
    check_idle_state("midrst_t2");

    // Random traffic until the counter saturates, then some more.
    for (int i = 0; i < 3000 && m_cnt < CNT_MAX; i++) begin
      ld  = ($urandom % 6) == 0;
      dir = (($urandom % 10) < 8) ? int'($urandom % 4) : int'(4 + $urandom % 4);
      do_req(ld, dir, int'($urandom % GW), int'($urandom % GH), 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      ld  = ($urandom % 6) == 0;
      dir = int'($urandom % 8);
      do_req(ld, dir, int'($urandom % GW), int'($urandom % GH), 1'b0);
    end
    chk("saturated", int'(bus.step_count), CNT_MAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grid_navigator.md
Name: grid_navigator

Overview:
- Clocked successor to the combinational forbidden-move filter.
- Holds the player's registered map position and accepts move or teleport requests over a valid/ready handshake.
- Checks each target cell against grid bounds and a parametrised wall bitmap, then commits or rejects it.
- Sits between the input/command decoder and the room/display logic; reports result pulses and a saturating step counter.

Parameters:
- GRID_W, 8, grid columns (≥2).
- GRID_H, 4, grid rows (≥2).
- X_W, 3, x coordinate width, ≥ clog2(GRID_W).
- Y_W, 2, y coordinate width, ≥ clog2(GRID_H).
- START_X, 0, reset x position; must not be a wall.
- START_Y, 0, reset y position; must not be a wall.
- WALL_MAP, 32'h44451048, GRID_W*GRID_H bits; bit y*GRID_W+x = 1 marks a wall. The default reproduces the current level walls: (3,0) (6,0) (4,1) (0,2) (2,2) (6,2) (2,3) (6,3).
- CNT_W, 8, step counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_dir  in  3  0=UP (y-1), 1=DOWN (y+1), 2=RIGHT (x+1), 3=LEFT (x-1), 4=NONE, 5-7 treated as NONE.
- req_load  in  1  teleport request; takes priority over req_dir.
- load_x  in  X_W  teleport target x.
- load_y  in  Y_W  teleport target y.
- pos_x  out  X_W  current x.
- pos_y  out  Y_W  current y.
- done  out  1  one-cycle result pulse.
- blocked  out  1  qualifies done: 1 means the target was rejected.
- step_count  out  CNT_W  number of committed position changes.

Interface (already decided):
- One clock; reset is asynchronous and active-low.
- All outputs are registered.

Behaviour:
- Reset values:
  - pos_x=START_X, pos_y=START_Y.
  - done=0, blocked=0, step_count=0.
  - State IDLE, so req_ready=1.
- FSM:
  - IDLE: handshake when req_valid && req_ready.
    - Latch target: load_x/load_y if req_load, else pos ± 1 per req_dir.
    - Compute target in X_W+1 / Y_W+1 bit signed width, so no implicit wrap.
    - Go to CHECK.
  - CHECK: reject if x<0, x≥GRID_W, y<0, y≥GRID_H, or WALL_MAP bit set. Go to COMMIT.
  - COMMIT:
    - If not rejected: pos updates to the target.
    - done=1 for one cycle, blocked=reject.
    - step_count increments only if the position actually changed; it saturates at 2^CNT_W-1.
    - Return to IDLE.
- Latency: handshake at cycle T, pos/done visible at T+2. A new request can be accepted at T+3, so at most one request per 3 cycles.
- NONE and codes 5-7: done=1, blocked=0, pos unchanged, no count.
- Teleport to the current cell: done=1, blocked=0, no count.
- Teleport into a wall or out of range: blocked=1, pos unchanged.
- req_valid held high: a fresh request is taken each time IDLE is re-entered. The requester must drop req_valid after the handshake or accept repeats.
- req_load, load_x, load_y and req_dir are ignored outside the handshake cycle.
- rst_n asserted mid-operation: immediate return to reset values; any in-flight request is discarded with no done pulse.
- blocked holds its value between done pulses; it is only meaningful when done=1.

Optional Feature:
- Macro: GRID_NAVIGATOR_WRAP_EN.
- Defined: moves off an edge wrap toroidally (x=-1 → GRID_W-1, x=GRID_W → 0; same for y). Wall check applies to the wrapped cell. Out-of-range teleports are still blocked.
- Undefined: edge moves are blocked as described above.

Decomposition:
- Shared package/include zork_pkg:
  - direction localparams UP/DOWN/RIGHT/LEFT/NONE;
  - state encodings IDLE/CHECK/COMMIT;
  - default level WALL_MAP constant.
- One natural sub-module: grid_cell_check. It is combinational and takes signed target x/y, outputting in_range, is_wall and, under the macro, the wrapped coordinates. It is reused by the room/display logic.

Test Plan:
- Reset: rst_n low → pos=(0,0), step_count=0, req_ready=1, done=0.
- Open move: RIGHT from (0,0) → at T+2 pos=(1,0), done=1, blocked=0, step_count=1.
- Wall: RIGHT from (2,0) → target (3,0) is a wall; pos stays (2,0), done=1, blocked=1, count unchanged.
- Edge: UP from (0,0) → blocked=1, pos (0,0). With GRID_NAVIGATOR_WRAP_EN → pos=(0,3).
- Teleport: req_load with (5,3) → pos=(5,3). Teleport to (6,3) → blocked. Teleport while the FSM is in CHECK is not accepted, since req_ready=0.
- Saturation and reset: CNT_W=2, four committed moves → step_count=3. Assert rst_n in CHECK → no done pulse, pos back to (START_X,START_Y).
